// File: rtl/exec_unit_pkg.sv
// exec_unit_pkg: shared ALU/branch opcode encodings and the execute stage register layout
package exec_unit_pkg;
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;
  localparam logic [4:0] ALU_NOR    = 5'd5;
  localparam logic [4:0] ALU_SLT    = 5'd6;
  localparam logic [4:0] ALU_SLTU   = 5'd7;
  localparam logic [4:0] ALU_SLL    = 5'd8;
  localparam logic [4:0] ALU_SRL    = 5'd9;
  localparam logic [4:0] ALU_SRA    = 5'd10;
  localparam logic [4:0] ALU_LUI    = 5'd11;
  localparam logic [4:0] ALU_PCLINK = 5'd12;
  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_BEQ  = 4'd1;
  localparam logic [3:0] BR_BNE  = 4'd2;
  localparam logic [3:0] BR_BLEZ = 4'd3;
  localparam logic [3:0] BR_BGTZ = 4'd4;
  localparam logic [3:0] BR_BLTZ = 4'd5;
  localparam logic [3:0] BR_BGEZ = 4'd6;
  localparam logic [3:0] BR_J    = 4'd7;
  localparam logic [3:0] BR_JR   = 4'd8;
  typedef struct packed {
    logic        dmem_we;
    logic        reg_we;
    logic        s_byte;
    logic        s_wrd;
    logic        s_a;
    logic        s_b;
    logic        s_rs;
    logic [3:0]  br_op;
    logic [4:0]  alu_op;
    logic [4:0]  wra;
    logic [25:0] low_pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] num;
    logic [31:0] pc;
  } stage_t;
endpackage

// File: rtl/exec_unit_alu.sv
// exec_unit_alu: combinational 32-bit ALU (ports: a, b, op -> y)
module exec_unit_alu
  import exec_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  op,
  output logic [31:0] y
);
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_AND:    y = a & b;
      ALU_OR:     y = a | b;
      ALU_XOR:    y = a ^ b;
      ALU_NOR:    y = ~(a | b);
      ALU_SLT:    y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:   y = {31'b0, a < b};
      ALU_SLL:    y = b << a[4:0];
      ALU_SRL:    y = b >> a[4:0];
      ALU_SRA:    y = $signed(b) >>> a[4:0];
      ALU_LUI:    y = {b[15:0], 16'b0};
      ALU_PCLINK: y = a + 32'd8;
      default:    y = '0;
    endcase
  end
endmodule

// File: rtl/exec_unit_branch_unit.sv
// exec_unit_branch_unit: combinational branch/jump resolution (ports: br_op, a, b, pc, low_pc -> next_pc, clr)
module exec_unit_branch_unit
  import exec_unit_pkg::*;
(
  input  logic [3:0]  br_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc,
  input  logic [25:0] low_pc,
  output logic [31:0] next_pc,
  output logic        clr
);
  logic [31:0] seq, boff, target;
  logic        taken;
  assign seq  = pc + 32'd4;
  assign boff = seq + {{14{low_pc[15]}}, low_pc[15:0], 2'b00};
  always_comb begin
    taken  = 1'b0;
    target = boff;
    case (br_op)
      BR_BEQ:  taken = a == b;
      BR_BNE:  taken = a != b;
      BR_BLEZ: taken = a[31] || a == '0;
      BR_BGTZ: taken = !a[31] && a != '0;
      BR_BLTZ: taken = a[31];
      BR_BGEZ: taken = !a[31];
      BR_J: begin
        taken  = 1'b1;
        target = {seq[31:28], low_pc, 2'b00};
      end
      BR_JR: begin
        taken  = 1'b1;
        target = a;
      end
      default: taken = 1'b0;
    endcase
  end
  assign next_pc = taken ? target : seq;
  assign clr     = taken;
endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute stage register, operand select, ALU and branch resolution (decode-side i_* in, memory-side o_* out)
module exec_unit
  import exec_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_dmemWe,
  input  logic        i_regWe,
  input  logic        i_sByte,
  input  logic        i_sWRD,
  input  logic        i_sA,
  input  logic        i_sB,
  input  logic        i_srs,
  input  logic        i_pause,
  input  logic [3:0]  i_brOP,
  input  logic [4:0]  i_aluOP,
  input  logic [4:0]  i_WRA,
  input  logic [25:0] i_lowPC,
  input  logic [31:0] i_rd1,
  input  logic [31:0] i_rd2,
  input  logic [31:0] i_num,
  input  logic [31:0] i_PC,
  output logic        o_dmemWe,
  output logic        o_regWe,
  output logic        o_sByte,
  output logic        o_sWRD,
  output logic [4:0]  o_WRA,
  output logic [31:0] o_rd2,
  output logic [31:0] o_aluOut,
  output logic [31:0] o_PC,
  output logic        o_clr
);
  stage_t r, d;
  logic [31:0] rs_a, op_a, op_b;
  assign d = '{dmem_we: i_dmemWe, reg_we: i_regWe, s_byte: i_sByte, s_wrd: i_sWRD,
               s_a: i_sA, s_b: i_sB, s_rs: i_srs, br_op: i_brOP, alu_op: i_aluOP,
               wra: i_WRA, low_pc: i_lowPC, rd1: i_rd1, rd2: i_rd2, num: i_num, pc: i_PC};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r <= '0;
    else if (!i_pause) r <= d;
  assign rs_a = r.s_rs ? r.pc : r.rd1;
  assign op_a = r.s_a ? r.num : rs_a;
  assign op_b = r.s_b ? r.rd2 : r.num;
  exec_unit_alu u_alu (
    .a  (op_a),
    .b  (op_b),
    .op (r.alu_op),
    .y  (o_aluOut)
  );
  exec_unit_branch_unit u_br (
    .br_op   (r.br_op),
    .a       (r.rd1),
    .b       (r.rd2),
    .pc      (r.pc),
    .low_pc  (r.low_pc),
    .next_pc (o_PC),
    .clr     (o_clr)
  );
  assign o_dmemWe = r.dmem_we;
  assign o_regWe  = r.reg_we;
  assign o_sByte  = r.s_byte;
  assign o_sWRD   = r.s_wrd;
  assign o_WRA    = r.wra;
  assign o_rd2    = r.rd2;
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: self-checking bench for exec_unit with a behavioural model and directed vectors
module tb_exec_unit;
  typedef struct packed {
    logic        dwe, rwe, sbyte, swrd, sa, sb, srs, pause;
    logic [3:0]  br;
    logic [4:0]  op, wra;
    logic [25:0] lpc;
    logic [31:0] rd1, rd2, num, pc;
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  vec_t cur = '0;
  vec_t held = '0;
  int checks = 0;
  int failures = 0;
  logic o_dmemWe, o_regWe, o_sByte, o_sWRD, o_clr;
  logic [4:0] o_WRA;
  logic [31:0] o_rd2, o_aluOut, o_PC;
  always #5 clk = ~clk;
  exec_unit dut (
    .clk(clk), .rstn(rstn),
    .i_dmemWe(cur.dwe), .i_regWe(cur.rwe), .i_sByte(cur.sbyte), .i_sWRD(cur.swrd),
    .i_sA(cur.sa), .i_sB(cur.sb), .i_srs(cur.srs), .i_pause(cur.pause),
    .i_brOP(cur.br), .i_aluOP(cur.op), .i_WRA(cur.wra), .i_lowPC(cur.lpc),
    .i_rd1(cur.rd1), .i_rd2(cur.rd2), .i_num(cur.num), .i_PC(cur.pc),
    .o_dmemWe(o_dmemWe), .o_regWe(o_regWe), .o_sByte(o_sByte), .o_sWRD(o_sWRD),
    .o_WRA(o_WRA), .o_rd2(o_rd2), .o_aluOut(o_aluOut), .o_PC(o_PC), .o_clr(o_clr)
  );
  function automatic logic [31:0] exp_alu(vec_t v);
    logic [31:0] a, b;
    int unsigned sh;
    a  = v.sa ? v.num : (v.srs ? v.pc : v.rd1);
    b  = v.sb ? v.rd2 : v.num;
    sh = a % 32;
    case (v.op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~(a | b);
      6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      7:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      8:  return 32'(longint'(b) * (longint'(1) << sh));
      9:  return 32'(longint'(b) / (longint'(1) << sh));
      10: return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      11: return b * 32'h0001_0000;
      12: return a + 32'd8;
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [32:0] exp_br(vec_t v);
    int sa;
    logic [31:0] seq, boff;
    sa   = int'(v.rd1);
    seq  = v.pc + 32'd4;
    boff = seq + 32'(int'($signed(v.lpc[15:0])) * 4);
    case (v.br)
      1: return (v.rd1 == v.rd2) ? {1'b1, boff} : {1'b0, seq};
      2: return (v.rd1 != v.rd2) ? {1'b1, boff} : {1'b0, seq};
      3: return (sa <= 0) ? {1'b1, boff} : {1'b0, seq};
      4: return (sa > 0) ? {1'b1, boff} : {1'b0, seq};
      5: return (sa < 0) ? {1'b1, boff} : {1'b0, seq};
      6: return (sa >= 0) ? {1'b1, boff} : {1'b0, seq};
      7: return {1'b1, seq[31:28], v.lpc, 2'b00};
      8: return {1'b1, v.rd1};
      default: return {1'b0, seq};
    endcase
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    #1;
    if (rstn && !cur.pause) held = cur;
  endtask
  always @(negedge clk) begin
    logic [32:0] br;
    br = exp_br(held);
    chk("m_alu", o_aluOut, exp_alu(held));
    chk("m_pc", o_PC, br[31:0]);
    chk("m_clr", {31'b0, o_clr}, {31'b0, br[32]});
    chk("m_rd2", o_rd2, held.rd2);
    chk("m_pass", {23'b0, o_WRA, o_dmemWe, o_regWe, o_sByte, o_sWRD},
        {23'b0, held.wra, held.dwe, held.rwe, held.sbyte, held.swrd});
  end
  initial begin
    #1;
    chk("rst_alu", o_aluOut, 32'd0);
    chk("rst_clr", {31'b0, o_clr}, 32'd0);
    chk("rst_pc", o_PC, 32'd4);
    cycle();
    rstn = 1'b1;
    cur = '{dwe:1, rwe:1, sbyte:1, swrd:1, sa:0, sb:1, srs:0, pause:0, br:7, op:0, wra:5'd7,
            lpc:26'h3ff_ffff, rd1:32'hdead_beef, rd2:32'h55, num:32'h11, pc:32'h1000};
    cycle();
    cur.pause = 1'b1;
    #2 rstn = 1'b0;
    held = '0;
    #1;
    chk("arst_alu", o_aluOut, 32'd0);
    chk("arst_clr", {31'b0, o_clr}, 32'd0);
    chk("arst_pc", o_PC, 32'd4);
    chk("arst_rd2", o_rd2, 32'd0);
    chk("arst_wra", {27'b0, o_WRA}, 32'd0);
    cycle();
    rstn = 1'b1;
    cycle();
    cur = '0;
    cur.rd1 = 32'hFFFF_FFFF; cur.num = 32'd1;
    cycle();
    chk("add_wrap", o_aluOut, 32'd0);
    cur.op = 5'd6; cur.rd2 = 32'd1; cur.sb = 1'b1;
    cycle();
    chk("slt", o_aluOut, 32'd1);
    cur.op = 5'd7;
    cycle();
    chk("sltu", o_aluOut, 32'd0);
    cur.op = 5'd10; cur.num = 32'd4; cur.sa = 1'b1; cur.rd2 = 32'h8000_0000;
    cycle();
    chk("sra", o_aluOut, 32'hF800_0000);
    cur = '0;
    cur.br = 4'd1; cur.pc = 32'h100; cur.rd1 = 32'd5; cur.rd2 = 32'd5; cur.lpc = 26'hFFFE;
    cycle();
    chk("beq_clr", {31'b0, o_clr}, 32'd1);
    chk("beq_pc", o_PC, 32'h0FC);
    cur.rd2 = 32'd6;
    cycle();
    chk("beq_nt_clr", {31'b0, o_clr}, 32'd0);
    chk("beq_nt_pc", o_PC, 32'h104);
    cur = '0;
    cur.br = 4'd7; cur.pc = 32'h4000_0010; cur.lpc = 26'h40;
    cycle();
    chk("j_pc", o_PC, 32'h4000_0100);
    chk("j_clr", {31'b0, o_clr}, 32'd1);
    cur.br = 4'd8; cur.rd1 = 32'h1234;
    cycle();
    chk("jr_pc", o_PC, 32'h1234);
    chk("jr_clr", {31'b0, o_clr}, 32'd1);
    cur = '0;
    cur.srs = 1'b1; cur.pc = 32'h200; cur.op = 5'd12;
    cycle();
    chk("pclink", o_aluOut, 32'h208);
    cur = '0;
    cur.rd1 = 32'd10; cur.num = 32'd5; cur.wra = 5'd3;
    cycle();
    chk("stall_x", o_aluOut, 32'd15);
    cur.pause = 1'b1; cur.rd1 = 32'h100; cur.wra = 5'd9;
    cycle();
    chk("stall_hold_alu", o_aluOut, 32'd15);
    chk("stall_hold_wra", {27'b0, o_WRA}, 32'd3);
    cycle();
    chk("stall_hold2", o_aluOut, 32'd15);
    cur.pause = 1'b0;
    cycle();
    chk("stall_y_alu", o_aluOut, 32'h105);
    chk("stall_y_wra", {27'b0, o_WRA}, 32'd9);
    for (int i = 0; i < 48; i++) begin
      cur.dwe = 1'($urandom); cur.rwe = 1'($urandom);
      cur.sbyte = 1'($urandom); cur.swrd = 1'($urandom);
      cur.sa = 1'($urandom); cur.sb = 1'($urandom); cur.srs = 1'($urandom);
      cur.pause = (i % 5 == 4);
      cur.op = 5'(i % 32); cur.br = 4'(i % 16);
      cur.wra = 5'($urandom); cur.lpc = 26'($urandom);
      cur.rd1 = (i % 4 == 1) ? 32'd0 : $urandom; cur.rd2 = (i % 3 == 0) ? cur.rd1 : $urandom;
      cur.num = $urandom; cur.pc = $urandom;
      cycle();
    end
    cur.pause = 1'b0;
    cycle();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
